// File: rtl/train_step_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default operand widths and the step-counter width.
package train_step_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIN0_W     = 8;
  localparam int DIN1_W     = 4;
  localparam int DOUT_W     = DIN0_W;
  localparam int STEP_CNT_W = $clog2(DIN0_W + 1);

endpackage

// File: rtl/train_step_udiv_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// The partial remainder is always below the divisor, so it fits in
// div_w bits; the shifted trial value needs one extra bit.
module train_step_udiv_step #(
  parameter int div_w = 4
) (
  input  logic [div_w-1:0] prem,
  input  logic             next_bit,
  input  logic [div_w-1:0] dmag,
  output logic [div_w-1:0] prem_next,
  output logic             qbit
);

  logic [div_w:0] trial;
  logic [div_w:0] diff;

  // Shift in the next dividend bit and subtract when the divisor fits.
  always_comb begin
    trial = {prem, next_bit};
    diff  = trial - {1'b0, dmag};
    qbit  = (trial >= {1'b0, dmag});
    prem_next = qbit ? diff[div_w-1:0] : trial[div_w-1:0];
  end

endmodule

// File: rtl/train_step_sdiv_seq.sv
// Sequential signed divider: accepts an operand pair in IDLE, runs one
// restoring step per CALC cycle for din0_WIDTH cycles, then presents a
// sign-corrected quotient/remainder in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both 1; valid never waits on ready, and once out_valid is high the
// result stays stable until the edge with out_ready=1.
module train_step_sdiv_seq
  import train_step_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = din0_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int                CNT_W    = $clog2(din0_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(din0_WIDTH - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in.
  logic [din0_WIDTH-1:0] a_sh;
  logic [din1_WIDTH-1:0] prem;
  logic [din1_WIDTH-1:0] b_mag;
  logic                  neg_q;
  logic                  neg_r;
  logic                  dz;
  logic [din1_WIDTH-1:0] dz_rem;

  logic [din1_WIDTH-1:0] prem_next;
  logic                  qbit;
  logic [din0_WIDTH-1:0] q_fin;
  logic [dout_WIDTH-1:0] q_signed;
  logic [din1_WIDTH-1:0] r_signed;

  train_step_udiv_step #(
    .div_w (din1_WIDTH)
  ) u_step (
    .prem      (prem),
    .next_bit  (a_sh[din0_WIDTH-1]),
    .dmag      (b_mag),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  // Ready is masked during reset so the block never advertises acceptance
  // while held in reset, yet is high on the first cycle after release.
  always_comb begin
    in_ready  = (state == ST_IDLE) && ap_rst_n;
    out_valid = (state == ST_DONE);
  end

  // Sign fix-up of the final step's results; negation wraps modulo 2^width.
  always_comb begin
    q_fin    = {a_sh[din0_WIDTH-2:0], qbit};
    q_signed = neg_q ? (dout_WIDTH'(0) - dout_WIDTH'(q_fin)) : dout_WIDTH'(q_fin);
    r_signed = neg_r ? (din1_WIDTH'(0) - prem_next) : prem_next;
  end

  // FSM, step counter, operand registers and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      prem     <= '0;
      b_mag    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      dz_rem   <= '0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh   <= din0[din0_WIDTH-1] ? (din0_WIDTH'(0) - din0) : din0;
            b_mag  <= din1[din1_WIDTH-1] ? (din1_WIDTH'(0) - din1) : din1;
            neg_q  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            neg_r  <= din0[din0_WIDTH-1];
            dz     <= (din1 == '0);
            dz_rem <= din0[din1_WIDTH-1:0];
            prem   <= '0;
            cnt    <= '0;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          a_sh <= q_fin;
          prem <= prem_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state    <= ST_DONE;
            quot     <= dz ? '1 : q_signed;
            rem      <= dz ? dz_rem : r_signed;
            div_zero <= dz;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/train_step_sdiv_seq.md
TRAIN_STEP_SDIV_SEQ -- requirements
Module: train_step_sdiv_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- din0_WIDTH, 8, dividend width.
- din1_WIDTH, 4, divisor width.
- dout_WIDTH, 8, quotient width; equals din0_WIDTH.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- ap_clk, in, 1, single clock, rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operand pair valid.
- in_ready, out, 1, block can accept operands.
- din0, in, din0_WIDTH, signed dividend.
- din1, in, din1_WIDTH, signed divisor.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- quot, out, dout_WIDTH, signed quotient.
- rem, out, din1_WIDTH, signed remainder.
- div_zero, out, 1, divisor was zero.
REQ-003 Reset SHALL be asynchronous and active-low on ap_rst_n. The block SHALL have one clock, ap_clk.

Function
REQ-004 FSM states SHALL be IDLE, CALC and DONE. Reset state is IDLE.
REQ-005 in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-006 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1. At acceptance the block SHALL:
- latch the operand magnitudes and signs;
- clear the step counter;
- move to CALC.
REQ-007 CALC SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes.
REQ-008 After exactly din0_WIDTH CALC cycles the FSM SHALL enter DONE. out_valid SHALL rise din0_WIDTH cycles after the acceptance edge.
REQ-009 Quotient SHALL truncate toward zero. Quotient is negative iff the operand signs differ. Remainder SHALL take the dividend's sign, with |rem| < |din1|.
REQ-010 Quotient negation SHALL wrap modulo 2^dout_WIDTH. For example, -128 / -1 SHALL give quot=-128, rem=0, div_zero=0.
REQ-011 When din1=0, the block SHALL still spend din0_WIDTH CALC cycles and then return quot=all-ones, rem=din0 truncated to din1_WIDTH, div_zero=1.
REQ-012 In DONE, quot, rem and div_zero SHALL stay stable while out_ready=0.
REQ-013 On an edge with out_valid=1 and out_ready=1 the FSM SHALL return to IDLE. A new operand pair SHALL NOT be accepted on that same edge.
REQ-014 Operand changes on din0/din1 outside the acceptance edge SHALL have no effect.
REQ-015 in_valid asserted during CALC or DONE SHALL be ignored, and in_ready SHALL stay 0.

Reset
REQ-016 While ap_rst_n=0 the outputs SHALL be in_ready=0, out_valid=0, quot=0, rem=0, div_zero=0.
REQ-017 After ap_rst_n deasserts, the FSM SHALL be in IDLE with in_ready=1 from the first cycle.
REQ-018 Reset asserted mid-CALC or mid-DONE SHALL abort the operation immediately and discard any partial result.

Structure
REQ-019 Package train_step_div_pkg SHALL hold:
- the FSM state enum (IDLE/CALC/DONE);
- the default width constants;
- a step-counter width constant of clog2(din0_WIDTH+1).
REQ-020 Sub-module train_step_udiv_step SHALL implement one combinational shift-subtract iteration:
- inputs: partial remainder, next dividend bit, divisor magnitude;
- outputs: new partial remainder, quotient bit.
REQ-021 The top level SHALL hold the FSM, the counter, the operand registers, and the sign fix-up.

Verification
REQ-022 din0=100, din1=7 -> out_valid 8 cycles after accept, quot=14, rem=2, div_zero=0.
REQ-023 Sign cases:
- din0=-100, din1=7 -> quot=-14, rem=-2.
- din0=100, din1=-7 -> quot=-14, rem=2.
REQ-024 din0=-128, din1=-1 -> quot=-128, rem=0. din0=5, din1=0 -> quot=0xFF, rem=5, div_zero=1.
REQ-025 din0=50, din1=3 with out_ready=0 for 5 cycles in DONE -> quot=16, rem=2 held stable. in_ready=0 throughout. Single completion when out_ready=1.
REQ-026 Reset pulse on ap_rst_n at CALC cycle 3 -> outputs zero immediately. No out_valid follows. Next op 9/2 -> quot=4, rem=1.
